// File: rtl/msp_pkg.sv
// ---------------------------------------------------------------------------
// msp_pkg
// Shared definitions for the operand addressing-mode sequencer:
//   - state_t      : sequencer state encoding
//   - MC_*         : calc-unit mode codes driven on mc
//   - SEL_*        : memory address bus source codes driven on addr_sel
//   - AS_*         : source addressing mode codes (as_mode input)
//   - outs_t       : bundle of the registered Moore outputs
//   - helpers      : memory-request state test, destination routing,
//                    Moore output decode of a state
// ---------------------------------------------------------------------------
package msp_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    S_EXT   = 4'd1,
    S_CALC  = 4'd2,
    S_RD    = 4'd3,
    S_INC   = 4'd4,
    S_INCWB = 4'd5,
    D_EXT   = 4'd6,
    D_CALC  = 4'd7,
    D_RD    = 4'd8,
    EXEC    = 4'd9,
    WB      = 4'd10,
    DONE    = 4'd11
  } state_t;

  // Calc-unit mode codes
  localparam logic [1:0] MC_IDLE    = 2'd0;  // no calculation
  localparam logic [1:0] MC_SRC_INC = 2'd1;  // Sout + 1
  localparam logic [1:0] MC_SRC_MDB = 2'd2;  // Sout + MDB
  localparam logic [1:0] MC_DST_MDB = 2'd3;  // Dout + MDB

  // Memory address bus source codes
  localparam logic [1:0] SEL_PC   = 2'd0;
  localparam logic [1:0] SEL_RS   = 2'd1;
  localparam logic [1:0] SEL_CALC = 2'd2;

  // Source addressing modes
  localparam logic [1:0] AS_REG = 2'b00;  // Rn
  localparam logic [1:0] AS_IDX = 2'b01;  // X(Rn)
  localparam logic [1:0] AS_IND = 2'b10;  // @Rn
  localparam logic [1:0] AS_INC = 2'b11;  // @Rn+

  typedef struct packed {
    logic [1:0] mc;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       src_wb;
    logic       alu_en;
    logic       dst_reg_wr;
    logic       busy;
    logic       done;
  } outs_t;

  // True for the states that hold a memory request open until mem_ack.
  function automatic logic is_req_state(input state_t st);
    logic r;
    case (st)
      S_EXT, S_RD, D_EXT, D_RD, WB: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  // Where the sequence continues once the source operand is settled.
  function automatic state_t dest_state(input logic ad_m);
    state_t r;
    if (ad_m) begin
      r = D_EXT;
    end else begin
      r = EXEC;
    end
    return r;
  endfunction

  // Moore output decode for a state, given the captured addressing modes.
  function automatic outs_t decode_outs(input state_t st, input logic [1:0] as_m,
                                        input logic ad_m);
    outs_t o;
    o = '0;
    case (st)
      IDLE: begin
        o.busy = 1'b0;
      end
      S_EXT, D_EXT: begin
        o.busy     = 1'b1;
        o.mem_req  = 1'b1;
        o.addr_sel = SEL_PC;
      end
      S_CALC: begin
        o.busy = 1'b1;
        o.mc   = MC_SRC_MDB;
      end
      S_RD: begin
        o.busy    = 1'b1;
        o.mem_req = 1'b1;
        // Indexed source reads from the computed address, the indirect
        // modes read straight through the source register.
        if (as_m == AS_IDX) begin
          o.addr_sel = SEL_CALC;
        end else begin
          o.addr_sel = SEL_RS;
        end
      end
      S_INC: begin
        o.busy = 1'b1;
        o.mc   = MC_SRC_INC;
      end
      S_INCWB: begin
        o.busy   = 1'b1;
        o.src_wb = 1'b1;
      end
      D_CALC: begin
        o.busy = 1'b1;
        o.mc   = MC_DST_MDB;
      end
      D_RD: begin
        o.busy     = 1'b1;
        o.mem_req  = 1'b1;
        o.addr_sel = SEL_CALC;
      end
      EXEC: begin
        o.busy       = 1'b1;
        o.alu_en     = 1'b1;
        o.dst_reg_wr = ~ad_m;
      end
      WB: begin
        // mc stays on the destination calculation so CALC_OUT still
        // carries the write-back address.
        o.busy     = 1'b1;
        o.mem_req  = 1'b1;
        o.mem_we   = 1'b1;
        o.addr_sel = SEL_CALC;
        o.mc       = MC_DST_MDB;
      end
      DONE: begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/addr_mode_seq_ack_timer.sv
// ---------------------------------------------------------------------------
// ack_timer
// Counts cycles spent waiting for a memory acknowledge and flags expiry.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   clear  : restart the wait count (takes priority over count)
//   count  : one more cycle waited without acknowledge
//   expire : this waiting cycle is the LIMIT-th one (never when LIMIT = 0)
// ---------------------------------------------------------------------------
module ack_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] cnt;

  // Wait counter: cleared between accesses, advanced per unacknowledged cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (LIMIT != 0)) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // cnt holds the number of cycles already waited, so the LIMIT-th waiting
  // cycle is the one that sees LIMIT-1.
  assign expire = (LIMIT != 0) && count && (cnt == LAST);

endmodule

// File: rtl/addr_mode_seq.sv
// ---------------------------------------------------------------------------
// addr_mode_seq
// Operand addressing-mode sequencer: walks source/destination operand
// fetch, execute and memory write-back for the selected addressing modes.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   start      : begin a sequence (sampled only in IDLE)
//   as_mode    : source mode 00 Rn, 01 X(Rn), 10 @Rn, 11 @Rn+
//   ad_mode    : destination mode 0 Rn, 1 X(Rn)
//   mem_ack    : current memory access complete
//   mc         : calc-unit mode (0 idle, 1 Sout+1, 2 Sout+MDB, 3 Dout+MDB)
//   mem_req    : memory request, held until mem_ack
//   mem_we     : write qualifier for mem_req
//   addr_sel   : address source (0 PC, 1 Rs, 2 CALC_OUT)
//   pc_inc     : PC advance (extension word fetch acknowledged)
//   src_wb     : write CALC_OUT back to Rs
//   alu_en     : ALU execute strobe
//   dst_reg_wr : register destination write strobe
//   busy       : sequencer not in IDLE
//   done       : one-cycle completion pulse
//   fault      : one-cycle acknowledge-timeout pulse
// ---------------------------------------------------------------------------
module addr_mode_seq
  import msp_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] as_mode,
  input  logic       ad_mode,
  input  logic       mem_ack,
  output logic [1:0] mc,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] addr_sel,
  output logic       pc_inc,
  output logic       src_wb,
  output logic       alu_en,
  output logic       dst_reg_wr,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  state_t     state;
  state_t     nxt;
  logic [1:0] as_r;
  logic       ad_r;
  outs_t      outs_r;
  logic       fault_r;

  logic       accept;
  logic [1:0] as_eff;
  logic       ad_eff;
  logic       in_req;
  logic       expire;

  // A start is only honoured in IDLE; the modes used for the whole sequence
  // are the ones present on that cycle, later input changes are ignored.
  assign accept = (state == IDLE) && start;
  assign as_eff = accept ? as_mode : as_r;
  assign ad_eff = accept ? ad_mode : ad_r;
  assign in_req = is_req_state(state);

  // Each request state exits on mem_ack, so clearing on ack (or outside a
  // request state) gives every new access a fresh count.
  ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (~in_req | mem_ack),
    .count  (in_req & ~mem_ack),
    .expire (expire)
  );

  function automatic state_t next_state(input state_t st, input logic go,
                                        input logic [1:0] as_m, input logic ad_m,
                                        input logic ack, input logic tmo);
    state_t r;
    case (st)
      IDLE: begin
        if (go) begin
          case (as_m)
            AS_IDX:         r = S_EXT;
            AS_IND, AS_INC: r = S_RD;
            default:        r = dest_state(ad_m);
          endcase
        end else begin
          r = IDLE;
        end
      end
      S_EXT:   r = ack ? S_CALC : (tmo ? IDLE : S_EXT);
      S_CALC:  r = S_RD;
      S_RD: begin
        if (ack) begin
          r = (as_m == AS_INC) ? S_INC : dest_state(ad_m);
        end else if (tmo) begin
          r = IDLE;
        end else begin
          r = S_RD;
        end
      end
      S_INC:   r = S_INCWB;
      S_INCWB: r = dest_state(ad_m);
      D_EXT:   r = ack ? D_CALC : (tmo ? IDLE : D_EXT);
      D_CALC:  r = D_RD;
      D_RD:    r = ack ? EXEC : (tmo ? IDLE : D_RD);
      EXEC:    r = ad_m ? WB : DONE;
      WB:      r = ack ? DONE : (tmo ? IDLE : WB);
      DONE:    r = IDLE;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  assign nxt = next_state(state, accept, as_eff, ad_eff, mem_ack & in_req, expire);

  // Sequencer: state, captured modes and the outputs of the state being
  // entered, so every Moore output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      as_r    <= 2'b00;
      ad_r    <= 1'b0;
      outs_r  <= '0;
      fault_r <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        as_r <= as_mode;
        ad_r <= ad_mode;
      end else begin
        as_r <= as_r;
        ad_r <= ad_r;
      end
      outs_r  <= decode_outs(nxt, as_eff, ad_eff);
      fault_r <= expire;
    end
  end

  assign mc         = outs_r.mc;
  assign mem_req    = outs_r.mem_req;
  assign mem_we     = outs_r.mem_we;
  assign addr_sel   = outs_r.addr_sel;
  assign src_wb     = outs_r.src_wb;
  assign alu_en     = outs_r.alu_en;
  assign dst_reg_wr = outs_r.dst_reg_wr;
  assign busy       = outs_r.busy;
  assign done       = outs_r.done;
  assign fault      = fault_r;

  // PC advances in the same cycle the extension word is acknowledged.
  assign pc_inc = ((state == S_EXT) || (state == D_EXT)) && mem_ack;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Directed, table-driven bench for addr_mode_seq (ACK_TIMEOUT = 4).
module tb_addr_mode_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] as_mode;
  logic       ad_mode;
  logic       mem_ack;
  logic [1:0] mc;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] addr_sel;
  logic       pc_inc;
  logic       src_wb;
  logic       alu_en;
  logic       dst_reg_wr;
  logic       busy;
  logic       done;
  logic       fault;

  int total = 0;
  int bad   = 0;

  addr_mode_seq #(.ACK_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .as_mode    (as_mode),
    .ad_mode    (ad_mode),
    .mem_ack    (mem_ack),
    .mc         (mc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .pc_inc     (pc_inc),
    .src_wb     (src_wb),
    .alu_en     (alu_en),
    .dst_reg_wr (dst_reg_wr),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Output vector layout: {mc, mem_req, mem_we, addr_sel, pc_inc, src_wb,
  //                        alu_en, dst_reg_wr, busy, done, fault}
  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] MC1  = 13'h0800;
  localparam logic [12:0] MC2  = 13'h1000;
  localparam logic [12:0] MC3  = 13'h1800;
  localparam logic [12:0] REQ  = 13'h0400;
  localparam logic [12:0] WE   = 13'h0200;
  localparam logic [12:0] SEL1 = 13'h0080;
  localparam logic [12:0] SEL2 = 13'h0100;
  localparam logic [12:0] PCI  = 13'h0040;
  localparam logic [12:0] SWB  = 13'h0020;
  localparam logic [12:0] ALU  = 13'h0010;
  localparam logic [12:0] DWR  = 13'h0008;
  localparam logic [12:0] BSY  = 13'h0004;
  localparam logic [12:0] DN   = 13'h0002;
  localparam logic [12:0] FLT  = 13'h0001;

  typedef struct {
    string       name;
    logic        st;
    logic [1:0]  as_m;
    logic        ad_m;
    logic        ack;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] outs_now();
    return {mc, mem_req, mem_we, addr_sel, pc_inc, src_wb, alu_en, dst_reg_wr,
            busy, done, fault};
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = outs_now();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic st, input logic [1:0] as_m,
                     input logic ad_m, input logic ack, input logic [12:0] exp);
    vec_t v;
    v.name = name; v.st = st; v.as_m = as_m; v.ad_m = ad_m; v.ack = ack; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One cycle: drive inputs on the falling edge, check before the next rise.
  task automatic step(input string name, input logic st, input logic [1:0] as_m,
                      input logic ad_m, input logic ack, input logic [12:0] exp);
    @(negedge clk);
    start = st; as_mode = as_m; ad_mode = ad_m; mem_ack = ack;
    #1;
    check(name, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; as_mode = 2'b00; ad_mode = 1'b0; mem_ack = 1'b0;
    #2;
    check("reset_async", NONE);
    @(negedge clk);
    check("reset_held", NONE);
    rst = 1'b0;

    // Register source, register destination
    add("a_idle",  1'b1, 2'b00, 1'b0, 1'b0, NONE);
    add("a_exec",  1'b0, 2'b00, 1'b0, 1'b0, ALU | DWR | BSY);
    add("a_done",  1'b0, 2'b00, 1'b0, 1'b0, DN | BSY);
    add("a_back",  1'b0, 2'b00, 1'b0, 1'b0, NONE);

    // Indexed source, ack tied high
    add("b_idle",  1'b1, 2'b01, 1'b0, 1'b1, NONE);
    add("b_sext",  1'b0, 2'b01, 1'b0, 1'b1, REQ | PCI | BSY);
    add("b_scalc", 1'b0, 2'b01, 1'b0, 1'b1, MC2 | BSY);
    add("b_srd",   1'b0, 2'b01, 1'b0, 1'b1, REQ | SEL2 | BSY);
    add("b_exec",  1'b0, 2'b01, 1'b0, 1'b1, ALU | DWR | BSY);
    add("b_done",  1'b0, 2'b01, 1'b0, 1'b1, DN | BSY);
    add("b_ackidle", 1'b0, 2'b01, 1'b0, 1'b1, NONE);

    // Autoincrement source, indexed destination, two waits per access;
    // inputs scrambled while busy, ack and start pulsed in EXEC/DONE.
    add("c_idle",   1'b1, 2'b11, 1'b1, 1'b0, NONE);
    add("c_srd_w1", 1'b1, 2'b00, 1'b0, 1'b0, REQ | SEL1 | BSY);
    add("c_srd_w2", 1'b0, 2'b01, 1'b0, 1'b0, REQ | SEL1 | BSY);
    add("c_srd_ak", 1'b0, 2'b00, 1'b0, 1'b1, REQ | SEL1 | BSY);
    add("c_sinc",   1'b1, 2'b00, 1'b0, 1'b0, MC1 | BSY);
    add("c_sincwb", 1'b0, 2'b00, 1'b0, 1'b0, SWB | BSY);
    add("c_dext_w1",1'b0, 2'b00, 1'b0, 1'b0, REQ | BSY);
    add("c_dext_w2",1'b0, 2'b00, 1'b0, 1'b0, REQ | BSY);
    add("c_dext_ak",1'b0, 2'b00, 1'b0, 1'b1, REQ | PCI | BSY);
    add("c_dcalc",  1'b0, 2'b00, 1'b0, 1'b0, MC3 | BSY);
    add("c_drd_w1", 1'b0, 2'b00, 1'b0, 1'b0, REQ | SEL2 | BSY);
    add("c_drd_w2", 1'b0, 2'b00, 1'b0, 1'b0, REQ | SEL2 | BSY);
    add("c_drd_ak", 1'b0, 2'b00, 1'b0, 1'b1, REQ | SEL2 | BSY);
    add("c_exec",   1'b1, 2'b00, 1'b0, 1'b1, ALU | BSY);
    add("c_wb_w1",  1'b0, 2'b00, 1'b0, 1'b0, MC3 | REQ | WE | SEL2 | BSY);
    add("c_wb_w2",  1'b0, 2'b00, 1'b0, 1'b0, MC3 | REQ | WE | SEL2 | BSY);
    add("c_wb_ak",  1'b0, 2'b00, 1'b0, 1'b1, MC3 | REQ | WE | SEL2 | BSY);
    add("c_done",   1'b1, 2'b01, 1'b0, 1'b0, DN | BSY);
    add("c_idle1",  1'b0, 2'b01, 1'b0, 1'b0, NONE);
    add("c_idle2",  1'b0, 2'b01, 1'b0, 1'b0, NONE);

    // Indirect source, no ack: timeout after four waiting cycles
    add("d_idle",  1'b1, 2'b10, 1'b0, 1'b0, NONE);
    add("d_w1",    1'b0, 2'b10, 1'b0, 1'b0, REQ | SEL1 | BSY);
    add("d_w2",    1'b0, 2'b10, 1'b0, 1'b0, REQ | SEL1 | BSY);
    add("d_w3",    1'b0, 2'b10, 1'b0, 1'b0, REQ | SEL1 | BSY);
    add("d_w4",    1'b0, 2'b10, 1'b0, 1'b0, REQ | SEL1 | BSY);
    add("d_fault", 1'b0, 2'b10, 1'b0, 1'b0, FLT);
    add("d_quiet", 1'b0, 2'b10, 1'b0, 1'b0, NONE);

    // Indirect source, indexed destination, ack tied high
    add("f_idle",  1'b1, 2'b10, 1'b1, 1'b1, NONE);
    add("f_srd",   1'b0, 2'b10, 1'b1, 1'b1, REQ | SEL1 | BSY);
    add("f_dext",  1'b0, 2'b10, 1'b1, 1'b1, REQ | PCI | BSY);
    add("f_dcalc", 1'b0, 2'b10, 1'b1, 1'b1, MC3 | BSY);
    add("f_drd",   1'b0, 2'b10, 1'b1, 1'b1, REQ | SEL2 | BSY);
    add("f_exec",  1'b0, 2'b10, 1'b1, 1'b1, ALU | BSY);
    add("f_wb",    1'b0, 2'b10, 1'b1, 1'b1, MC3 | REQ | WE | SEL2 | BSY);
    add("f_done",  1'b0, 2'b10, 1'b1, 1'b1, DN | BSY);
    add("f_idle2", 1'b0, 2'b10, 1'b1, 1'b0, NONE);

    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].st, vecs[i].as_m, vecs[i].ad_m, vecs[i].ack, vecs[i].exp);
    end

    // Reset in the middle of a write-back, then a normal run afterwards
    step("r_idle",  1'b1, 2'b00, 1'b1, 1'b0, NONE);
    step("r_dext",  1'b0, 2'b00, 1'b1, 1'b1, REQ | PCI | BSY);
    step("r_dcalc", 1'b0, 2'b00, 1'b1, 1'b0, MC3 | BSY);
    step("r_drd",   1'b0, 2'b00, 1'b1, 1'b1, REQ | SEL2 | BSY);
    step("r_exec",  1'b0, 2'b00, 1'b1, 1'b0, ALU | BSY);
    step("r_wb",    1'b0, 2'b00, 1'b1, 1'b0, MC3 | REQ | WE | SEL2 | BSY);
    #1;
    mem_ack = 1'b1;
    rst = 1'b1;
    #1;
    check("r_async_clear", NONE);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("r_after_release", NONE);
    step("r2_idle", 1'b1, 2'b00, 1'b0, 1'b0, NONE);
    step("r2_exec", 1'b0, 2'b00, 1'b0, 1'b0, ALU | DWR | BSY);
    step("r2_done", 1'b0, 2'b00, 1'b0, 1'b0, DN | BSY);
    step("r2_back", 1'b0, 2'b00, 1'b0, 1'b0, NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_mode_seq.md
ADDR_MODE_SEQ -- requirements
Module: addr_mode_seq

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 16, max cycles to wait for mem_ack per access (0 disables timeout).
REQ-002 The block SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-004 The block SHALL have port start  in  1  begin operand sequence; sampled only in IDLE.
REQ-005 The block SHALL have port as_mode  in  2  source addressing mode: 00 Rn, 01 X(Rn), 10 @Rn, 11 @Rn+; captured on accepted start.
REQ-006 The block SHALL have port ad_mode  in  1  dest addressing mode: 0 Rn, 1 X(Rn); captured on accepted start.
REQ-007 The block SHALL have port mem_ack  in  1  memory access complete for the current request.
REQ-008 The block SHALL have port mc  out  2  calc-unit mode: 0 idle, 1 Sout+1, 2 Sout+MDB, 3 Dout+MDB.
REQ-009 The block SHALL have port mem_req  out  1  memory access request, held until mem_ack.
REQ-010 The block SHALL have port mem_we  out  1  write qualifier for mem_req.
REQ-011 The block SHALL have port addr_sel  out  2  MAB source: 0 PC, 1 Rs, 2 CALC_OUT.
REQ-012 The block SHALL have ports pc_inc, src_wb, alu_en, dst_reg_wr  out  1 each  one-cycle strobes: PC advance, write CALC_OUT to Rs, ALU execute, register-destination write.
REQ-013 The block SHALL have ports busy, done, fault  out  1 each  busy = not IDLE; done = one-cycle completion pulse; fault = one-cycle ack-timeout pulse.

Function
REQ-014 States SHALL be IDLE, S_EXT, S_CALC, S_RD, S_INC, S_INCWB, D_EXT, D_CALC, D_RD, EXEC, WB, DONE.
REQ-015 IDLE with start SHALL go: as_mode 01 -> S_EXT; 10/11 -> S_RD; 00 -> D_EXT if ad_mode=1 else EXEC.
REQ-016 S_EXT/D_EXT SHALL drive mem_req=1, mem_we=0, addr_sel=0; on mem_ack assert pc_inc same cycle and go to S_CALC/D_CALC.
REQ-017 S_CALC SHALL drive mc=2, D_CALC mc=3, one cycle each; next S_RD/D_RD (CALC_OUT is registered, valid the following cycle).
REQ-018 S_RD SHALL drive mem_req=1, addr_sel=2 if as_mode=01 else 1; on mem_ack go S_INC if as_mode=11, else D_EXT if ad_mode=1, else EXEC.
REQ-019 S_INC SHALL drive mc=1 one cycle; S_INCWB SHALL assert src_wb one cycle, then follow the destination rule of REQ-018.
REQ-020 D_RD SHALL drive mem_req=1, addr_sel=2; on mem_ack go EXEC.
REQ-021 EXEC SHALL assert alu_en one cycle; if ad_mode=0 also dst_reg_wr and go DONE, else go WB.
REQ-022 WB SHALL drive mem_req=1, mem_we=1, addr_sel=2 (CALC_OUT still holds D_CALC result, mc=0 elsewhere only after WB); on mem_ack go DONE.
REQ-023 mc SHALL be 0 in every state not named in REQ-017/REQ-019, except WB SHALL hold mc=3 so CALC_OUT stays valid.
REQ-024 DONE SHALL assert done one cycle and return to IDLE; start in DONE SHALL be ignored.
REQ-025 start while busy SHALL be ignored; as_mode/ad_mode changes while busy SHALL have no effect.
REQ-026 mem_ack outside a mem_req state SHALL be ignored.
REQ-027 Wait counter SHALL clear on entry to each mem_req state and increment per cycle without ack; reaching ACK_TIMEOUT SHALL pulse fault, drop mem_req, go IDLE with no done.
REQ-028 All strobes SHALL be Moore outputs of the current state except pc_inc (state AND mem_ack).

Reset
REQ-029 rst SHALL asynchronously force IDLE, clear captured modes and wait counter, and drive all outputs 0 (mc=0, addr_sel=0), including mid-access.

Structure
REQ-030 MC codes, addr_sel codes and state encoding SHALL live in shared package msp_pkg.
REQ-031 Timeout counter SHALL be sub-module ack_timer (clear, count, expire); FSM stays in addr_mode_seq.

Verification
REQ-032 As=00, Ad=0, start at cycle 0 -> cycle1 EXEC alu_en=dst_reg_wr=1, cycle2 done=1, cycle3 busy=0.
REQ-033 As=01, Ad=0, mem_ack tied 1 -> S_EXT(pc_inc) c1, mc=2 c2, S_RD addr_sel=2 c3, alu_en c4, done c5.
REQ-034 As=11, Ad=1, ack after 2 waits each -> order S_RD, mc=1, src_wb, D_EXT(pc_inc), mc=3, D_RD, EXEC, WB mem_we=1, done; exactly one each.
REQ-035 ACK_TIMEOUT=4, As=10, mem_ack held 0 -> fault pulse after 4 waiting cycles, mem_req=0, IDLE, no done.
REQ-036 rst asserted mid-WB between clock edges -> outputs 0 immediately; start after release runs normally.
REQ-037 start pulsed during busy and mem_ack pulsed in EXEC -> no state or output change.
